// File: rtl/byte_unstriper.sv
// Receive-side two-lane byte unstriper: re-interleaves lane 0 (even) and lane 1 (odd)
// bytes, each held for two clk_2f cycles, into one byte stream at the clk_2f rate.
//
// state | meaning
// IDLE  | unlocked; waiting for the first lane-0 valid to fix the capture phase
// RUN   | locked; capture on phase=0 edges, emit h0 then h1 alternately
module byte_unstriper #(
   parameter int DATA_WIDTH    = 8,
   parameter int IDLE_CAPTURES = 2,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_2f,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    data_stripe_0,
   input  logic                     valid_stripe_0,
   input  logic [DATA_WIDTH-1:0]    data_stripe_1,
   input  logic                     valid_stripe_1,
   output logic [DATA_WIDTH-1:0]    data_unstriped,
   output logic                     valid_unstriped,
   output logic                     stripe_error,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic                     locked
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0]               IDLE_LIMIT = 4'(IDLE_CAPTURES);
   localparam logic [3:0]               IDLE_ONE   = 4'd1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE    = ERR_CNT_WIDTH'(1);

   state_t                  state, state_nxt;
   logic                    phase, phase_nxt;
   logic [DATA_WIDTH-1:0]   h0, h1, h0_nxt, h1_nxt;
   logic                    hv0, hv1, hv0_nxt, hv1_nxt;
   logic [3:0]              idle_cnt, idle_cnt_nxt;
   logic [DATA_WIDTH-1:0]   data_nxt;
   logic                    valid_nxt;
   logic                    err_nxt;
   logic [ERR_CNT_WIDTH-1:0] cnt_nxt;

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state           <= IDLE;
         phase           <= 1'b0;
         h0              <= '0;
         h1              <= '0;
         hv0             <= 1'b0;
         hv1             <= 1'b0;
         idle_cnt        <= '0;
         data_unstriped  <= '0;
         valid_unstriped <= 1'b0;
         stripe_error    <= 1'b0;
         err_count       <= '0;
      end else begin
         state           <= state_nxt;
         phase           <= phase_nxt;
         h0              <= h0_nxt;
         h1              <= h1_nxt;
         hv0             <= hv0_nxt;
         hv1             <= hv1_nxt;
         idle_cnt        <= idle_cnt_nxt;
         data_unstriped  <= data_nxt;
         valid_unstriped <= valid_nxt;
         stripe_error    <= err_nxt;
         err_count       <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      h0_nxt       = h0;
      h1_nxt       = h1;
      hv0_nxt      = hv0;
      hv1_nxt      = hv1;
      idle_cnt_nxt = idle_cnt;
      data_nxt     = '0;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;
      cnt_nxt      = err_count;
      case (state)
         IDLE: begin
            if (valid_stripe_0) begin
               h0_nxt       = data_stripe_0;
               hv0_nxt      = 1'b1;
               h1_nxt       = data_stripe_1;
               hv1_nxt      = valid_stripe_1;
               idle_cnt_nxt = '0;
               phase_nxt    = 1'b1;
               state_nxt    = RUN;
            end
         end
         RUN: begin
            if (phase) begin
               valid_nxt = hv0;
               data_nxt  = hv0 ? h0 : '0;
               phase_nxt = 1'b0;
            end else begin
               // The lane 1 slot of the current pair is emitted on this edge in every case.
               valid_nxt = hv1;
               data_nxt  = hv1 ? h1 : '0;
               if (idle_cnt >= IDLE_LIMIT) begin
                  state_nxt    = IDLE;
                  phase_nxt    = 1'b0;
                  idle_cnt_nxt = '0;
                  h0_nxt       = '0;
                  h1_nxt       = '0;
                  hv0_nxt      = 1'b0;
                  hv1_nxt      = 1'b0;
               end else begin
                  h0_nxt    = data_stripe_0;
                  hv0_nxt   = valid_stripe_0;
                  h1_nxt    = data_stripe_1;
                  hv1_nxt   = valid_stripe_1;
                  phase_nxt = 1'b1;
                  if (!valid_stripe_0 && !valid_stripe_1)
                     idle_cnt_nxt = idle_cnt + IDLE_ONE;
                  else
                     idle_cnt_nxt = '0;
                  if (!valid_stripe_0 && valid_stripe_1) begin
                     err_nxt = 1'b1;
                     if (err_count != '1)
                        cnt_nxt = err_count + ERR_ONE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign locked = (state == RUN);

endmodule

// File: tb/tb_byte_unstriper.sv
// Directed bench for byte_unstriper: per-edge vector table plus a saturation sequence.
module tb_byte_unstriper;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic [7:0] data_stripe_0, data_stripe_1;
   logic       valid_stripe_0, valid_stripe_1;
   logic [7:0] data_unstriped;
   logic       valid_unstriped;
   logic       stripe_error;
   logic [7:0] err_count;
   logic       locked;

   int n_tests = 0;
   int n_fail  = 0;

   byte_unstriper #(.DATA_WIDTH(8), .IDLE_CAPTURES(2), .ERR_CNT_WIDTH(8)) dut (
      .clk_2f          (clk_2f),
      .reset           (reset),
      .data_stripe_0   (data_stripe_0),
      .valid_stripe_0  (valid_stripe_0),
      .data_stripe_1   (data_stripe_1),
      .valid_stripe_1  (valid_stripe_1),
      .data_unstriped  (data_unstriped),
      .valid_unstriped (valid_unstriped),
      .stripe_error    (stripe_error),
      .err_count       (err_count),
      .locked          (locked)
   );

   always #5 clk_2f = ~clk_2f;

   typedef struct {
      logic       rst;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       ev;
      logic [7:0] ed;
      logic       ee;
      logic       el;
      logic [7:0] ec;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic ev,
                      input logic [7:0] ed, input logic ee, input logic el,
                      input logic [7:0] ec);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.ev = ev; v.ed = ed; v.ee = ee; v.el = el; v.ec = ec;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // One clk_2f edge: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic drive(input logic rst, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
      @(negedge clk_2f);
      reset          = rst;
      valid_stripe_0 = v0;
      data_stripe_0  = d0;
      valid_stripe_1 = v1;
      data_stripe_1  = d1;
      @(posedge clk_2f);
      #1;
   endtask

   initial begin
      int exp_cnt;
      reset = 1'b1;
      valid_stripe_0 = 1'b0; valid_stripe_1 = 1'b0;
      data_stripe_0 = '0;    data_stripe_1 = '0;

      //  rst v0 d0     v1 d1     ev ed     ee el cnt
      // reset, then 4-byte stream
      add(1, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00); // 0
      add(0, 1, 8'h11, 1, 8'h22,  0, 8'h00, 0, 1, 8'h00); // 1 lock edge
      add(0, 1, 8'h11, 1, 8'h22,  1, 8'h11, 0, 1, 8'h00); // 2
      add(0, 1, 8'h33, 1, 8'h44,  1, 8'h22, 0, 1, 8'h00); // 3
      add(0, 1, 8'h33, 1, 8'h44,  1, 8'h33, 0, 1, 8'h00); // 4
      add(0, 0, 8'h00, 0, 8'h00,  1, 8'h44, 0, 1, 8'h00); // 5 empty, idle=1
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 6
      // odd tail
      add(0, 1, 8'hA0, 1, 8'hA1,  0, 8'h00, 0, 1, 8'h00); // 7
      add(0, 1, 8'hA0, 1, 8'hA1,  1, 8'hA0, 0, 1, 8'h00); // 8
      add(0, 1, 8'hA2, 0, 8'h5A,  1, 8'hA1, 0, 1, 8'h00); // 9
      add(0, 1, 8'hA2, 0, 8'h5A,  1, 8'hA2, 0, 1, 8'h00); // 10
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 11 empty slot, idle=1
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 12
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 13 idle=2
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 14
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00); // 15 lane1 slot, drop
      // re-lock on the opposite parity
      add(0, 1, 8'hB0, 1, 8'hB1,  0, 8'h00, 0, 1, 8'h00); // 16
      add(0, 1, 8'hB0, 1, 8'hB1,  1, 8'hB0, 0, 1, 8'h00); // 17
      add(0, 1, 8'hC0, 1, 8'hC1,  1, 8'hB1, 0, 1, 8'h00); // 18
      add(0, 1, 8'hC0, 1, 8'hC1,  1, 8'hC0, 0, 1, 8'h00); // 19
      add(0, 0, 8'h00, 0, 8'h00,  1, 8'hC1, 0, 1, 8'h00); // 20 idle=1
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h00); // 21
      // violation
      add(0, 0, 8'h00, 1, 8'h5C,  0, 8'h00, 1, 1, 8'h01); // 22
      add(0, 0, 8'h00, 1, 8'h5C,  0, 8'h00, 0, 1, 8'h01); // 23
      add(0, 0, 8'h00, 0, 8'h00,  1, 8'h5C, 0, 1, 8'h01); // 24
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 1, 8'h01); // 25
      // reset between lane 0 and lane 1 output
      add(0, 1, 8'h77, 1, 8'h88,  0, 8'h00, 0, 1, 8'h01); // 26
      add(0, 1, 8'h77, 1, 8'h88,  1, 8'h77, 0, 1, 8'h01); // 27
      add(1, 1, 8'h77, 1, 8'h88,  0, 8'h00, 0, 0, 8'h00); // 28 reset
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00); // 29
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00); // 30
      // lane 1 noise while IDLE
      add(0, 0, 8'h00, 1, 8'hEE,  0, 8'h00, 0, 0, 8'h00); // 31
      add(0, 0, 8'h00, 1, 8'hEE,  0, 8'h00, 0, 0, 8'h00); // 32
      add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00); // 33

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].v0, vq[i].d0, vq[i].v1, vq[i].d1);
         chk("valid",  i, 32'(valid_unstriped), 32'(vq[i].ev));
         chk("data",   i, 32'(data_unstriped),  32'(vq[i].ed));
         chk("err",    i, 32'(stripe_error),    32'(vq[i].ee));
         chk("locked", i, 32'(locked),          32'(vq[i].el));
         chk("count",  i, 32'(err_count),       32'(vq[i].ec));
      end

      // Error counter saturation: lock, then 300 back-to-back violations.
      drive(0, 1, 8'h01, 1, 8'h02);
      chk("sat_lock", 0, 32'(locked), 32'd1);
      drive(0, 1, 8'h01, 1, 8'h02);
      chk("sat_first", 0, 32'(data_unstriped), 32'h01);
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 8'h00, 1, 8'h5C);
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         chk("sat_err",   i, 32'(stripe_error), 32'd1);
         chk("sat_count", i, 32'(err_count),    32'(exp_cnt));
         chk("sat_valid", i, 32'(valid_unstriped), 32'd1);
         chk("sat_data",  i, 32'(data_unstriped), (i == 0) ? 32'h02 : 32'h5C);
         drive(0, 0, 8'h00, 1, 8'h5C);
         chk("sat_err_low", i, 32'(stripe_error), 32'd0);
      end
      chk("sat_final", 0, 32'(err_count), 32'hFF);
      chk("sat_locked", 0, 32'(locked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/byte_unstriper.md
Name: byte_unstriper

Overview:
- Receive-side counterpart of the two-lane byte striper.
- Takes the two byte stripes (lane 0 = even bytes, lane 1 = odd bytes), each held for two clk_2f cycles, and re-interleaves them into one byte stream at the clk_2f rate.
- Sits between the per-lane PHY receive path and the demux.
- Locks its capture phase to the first valid lane-0 byte, drops back to idle after a configurable run of empty captures, and flags striping-order violations.

Parameters:
- DATA_WIDTH, 8: width of every data bus.
- IDLE_CAPTURES, 2: consecutive empty captures (both lane valids low) in RUN before returning to IDLE; range 1-15.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clk_2f  input  1  single clock, twice the lane byte rate.
- reset  input  1  synchronous, active-high reset.
- data_stripe_0  input  DATA_WIDTH  lane 0 byte (even positions).
- valid_stripe_0  input  1  lane 0 byte valid.
- data_stripe_1  input  DATA_WIDTH  lane 1 byte (odd positions).
- valid_stripe_1  input  1  lane 1 byte valid.
- data_unstriped  output  DATA_WIDTH  merged byte stream, registered.
- valid_unstriped  output  1  merged byte valid, registered.
- stripe_error  output  1  one-cycle pulse on striping violation.
- err_count  output  ERR_CNT_WIDTH  saturating count of violations.
- locked  output  1  high while FSM is in RUN.

Behaviour:
- Interface rule (decided): one clock, clk_2f; reset is synchronous and active-high. All state updates on the rising edge of clk_2f; no other clocks, no asynchronous reset.
- Reset (sampled high on a clk_2f edge), values after that edge:
  - data_unstriped=0, valid_unstriped=0, stripe_error=0, err_count=0, locked=0.
  - FSM=IDLE, phase=0, hold registers h0/h1/hv0/hv1=0, idle counter=0.
  - Reset mid-stream discards all held and in-flight bytes, with no partial output afterwards.
- FSM states: IDLE, RUN.
- IDLE:
  - Sample lanes every cycle.
  - On the first edge with valid_stripe_0=1: capture both lanes into h0/hv0/h1/hv1, set phase<=1, go to RUN.
  - valid_stripe_1=1 with valid_stripe_0=0 in IDLE is ignored (no error, no capture).
- RUN:
  - phase toggles every cycle.
  - phase=0 edge = capture edge: h regs load from the lanes.
  - Edge with phase=1: output <= h0/hv0.
  - Edge with phase=0: output <= h1/hv1, in the same edge as the new capture. Non-blocking semantics, so the old h1 is emitted.
- Latency:
  - Lane 0 byte appears on the output 1 cycle after its capture edge.
  - Lane 1 byte appears 2 cycles after its capture edge.
  - Output order is always lane 0 then lane 1.
- Output data gating: when the emitted hv is 0, data_unstriped=0 and valid_unstriped=0.
- Legal tail: valid_stripe_0=1, valid_stripe_1=0 (odd-length packet). Lane 0 byte is emitted with valid=1; the lane 1 slot has valid=0. No error.
- Violation: a capture in RUN with valid_stripe_1=1 and valid_stripe_0=0.
  - stripe_error=1 for exactly the cycle after the capture edge.
  - err_count increments, saturating at all-ones.
  - The lane 1 byte is still emitted in its slot with valid=1.
- Idle detection:
  - Idle counter increments on each RUN capture with both valids 0 and clears on any capture with either valid 1.
  - When it reaches IDLE_CAPTURES, the FSM goes to IDLE at the end of that pair's output (next phase=0 edge emits h1, then state=IDLE, locked=0, phase=0).
  - The lane 1 slot of the last pair is always emitted before leaving RUN.
- Re-lock: after returning to IDLE, the capture phase re-aligns to the next valid_stripe_0=1, which may be at either clk_2f parity.
- locked=1 in every cycle the FSM is in RUN (registered with the state).

Test Plan:
- Reset then a 4-byte stream: lanes present {0x11,0x22}, then {0x33,0x44}, each held 2 cycles, valids high. Required: output valid bytes 0x11,0x22,0x33,0x44 on consecutive cycles. First byte appears 1 cycle after the lock edge. locked=1.
- Odd tail: {0xA0,0xA1}, then {0xA2, valid1=0}. Required: 0xA0,0xA1,0xA2 valid, then one cycle valid=0, data=0. stripe_error stays 0.
- Violation: in RUN, a capture with valid0=0, valid1=1, data1=0x5C. Required: stripe_error pulses exactly one cycle, err_count 0->1, 0x5C emitted with valid=1 in the lane 1 slot. Repeat 300 times: err_count saturates at 0xFF.
- Idle drop and re-lock with IDLE_CAPTURES=2: two empty captures, then locked falls after the second pair's lane 1 slot. Present valid0 on the opposite clk_2f parity. Required: new lock, first byte output 1 cycle later, correct order.
- Reset mid-stream: assert reset for one cycle between lane 0 and lane 1 output of a pair {0x77,0x88}. Required: 0x88 never appears, all outputs 0 the cycle after reset, FSM in IDLE.
- IDLE noise: valid1=1 with valid0=0 while IDLE. Required: no output, stripe_error=0, err_count unchanged.
